if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 86 ++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: one PC register driving instruction memory and an
// IF/ID pipeline register with stall, flush, redirect and a fetch counter.
module if_stage #(
   parameter int unsigned          XLEN     = 32,
   parameter logic [XLEN-1:0]      RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_instr,
   output logic [XLEN-1:0] if_id_pc,
   output logic [XLEN-1:0] if_id_pc4,
   output logic [31:0]     if_id_instr,
   output logic            if_id_valid,
   output logic [31:0]     fetch_count
);

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_if_id_pc;
   logic [XLEN-1:0] r_if_id_pc4;
   logic [31:0]     r_if_id_instr;
   logic            r_if_id_valid;
   logic [31:0]     r_fetch_count;

   logic [XLEN-1:0] w_pc_plus4;
   logic [XLEN-1:0] w_pc_next;
   logic            w_ifid_load;
   logic            w_ifid_bubble;

   assign w_pc_plus4 = r_pc + XLEN'(4);

   // Priority below reset: redirect > stall > advance. A redirect always
   // squashes IF/ID, even when the stage is stalled or flushed.
   always_comb begin
      w_pc_next     = r_pc;
      w_ifid_load   = 1'b0;
      w_ifid_bubble = 1'b0;
      if (redirect) begin
         w_pc_next     = {redirect_pc[XLEN-1:2], 2'b00};
         w_ifid_bubble = 1'b1;
      end else if (stall) begin
         w_ifid_bubble = flush;
      end else begin
         w_pc_next = w_pc_plus4;
         if (flush) w_ifid_bubble = 1'b1;
         else       w_ifid_load   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc          <= RESET_PC;
         r_if_id_pc    <= '0;
         r_if_id_pc4   <= '0;
         r_if_id_instr <= '0;
         r_if_id_valid <= 1'b0;
         r_fetch_count <= '0;
      end else begin
         r_pc <= w_pc_next;
         if (w_ifid_bubble) begin
            r_if_id_pc    <= '0;
            r_if_id_pc4   <= '0;
            r_if_id_instr <= '0;
            r_if_id_valid <= 1'b0;
         end else if (w_ifid_load) begin
            r_if_id_pc    <= r_pc;
            r_if_id_pc4   <= w_pc_plus4;
            r_if_id_instr <= imem_instr;
            r_if_id_valid <= 1'b1;
            r_fetch_count <= r_fetch_count + 32'd1;
         end
      end
   end

   assign imem_addr   = r_pc;
   assign if_id_pc    = r_if_id_pc;
   assign if_id_pc4   = r_if_id_pc4;
   assign if_id_instr = r_if_id_instr;
   assign if_id_valid = r_if_id_valid;
   assign fetch_count = r_fetch_count;

endmodule
